// File: rtl/minmax_scan_if.sv
// minmax_scan_if
// Groups the operand stream (valid/ready) and the shared comparator
// request/grant port used by minmax_scan_ctrl.
//   master : environment side (operand source + comparator arbiter)
//   slave  : minmax_scan_ctrl side
// Signals:
//   in_valid/in_data/in_ready : operand stream, accepted on in_valid && in_ready
//   cmp_req/cmp_gnt           : comparator request, grant is same-cycle
//   cmp_a/cmp_b               : comparator operands (zero when not requesting)
//   cmp_msb                   : bit 15 of cmp_a - cmp_b, same-cycle
interface minmax_scan_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        cmp_req;
    logic        cmp_gnt;
    logic [15:0] cmp_a;
    logic [15:0] cmp_b;
    logic        cmp_msb;

    modport master (
        output in_valid, in_data, cmp_gnt, cmp_msb,
        input  in_ready, cmp_req, cmp_a, cmp_b
    );

    modport slave (
        input  in_valid, in_data, cmp_gnt, cmp_msb,
        output in_ready, cmp_req, cmp_a, cmp_b
    );
endinterface

// File: rtl/minmax_scan_ctrl.sv
// minmax_scan_ctrl
// Finds the minimum (less_i=1) or maximum (less_i=0) of a stream of 1..N_MAX
// 16-bit operands and reports the winner and its stream position. Ordering
// comes solely from the sign bit returned by the shared ALU comparator, so it
// follows the comparator's wrapped-difference rule exactly (no local compare).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : begin a scan (sampled only in IDLE)
//   less_i         : mode, latched at start
//   count_i        : operand count, latched at start, legal 1..N_MAX
//   bus            : operand stream + comparator port (slave modport)
//   busy_o         : high in every state except IDLE
//   done_o         : one-cycle pulse, result valid
//   result_o       : winning operand, held until next scan's first accept
//   result_idx_o   : stream position of the winner
//
// state | meaning
// IDLE  | waiting for a legal start
// FIRST | accept operand 0 as the initial winner, no comparator use
// SCAN  | compare each further operand against the winner via the comparator
// DONE  | one-cycle result pulse
module minmax_scan_ctrl #(
    parameter int N_MAX = 16,
    parameter int IDXW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            less_i,
    input  logic [IDXW:0]   count_i,
    minmax_scan_if.slave    bus,
    output logic            busy_o,
    output logic            done_o,
    output logic [15:0]     result_o,
    output logic [IDXW-1:0] result_idx_o
);

    localparam logic [IDXW:0] CNT_MAX = (IDXW+1)'(N_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic [15:0]     result_q;
    logic [IDXW-1:0] idx_q;
    logic [IDXW:0]   k_q;
    logic [IDXW:0]   k_d;
    logic [IDXW:0]   count_q;
    logic            less_q;

    logic            start_ok;
    logic            scan_acc;
    logic            in_ready;
    logic            cmp_req;
    logic [15:0]     cmp_a;
    logic [15:0]     cmp_b;

    assign start_ok = start_i && (count_i != '0) && (count_i <= CNT_MAX);
    assign scan_acc = bus.in_valid && bus.cmp_gnt;
    assign k_d      = k_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            idx_q    <= '0;
            k_q      <= '0;
            count_q  <= '0;
            less_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        count_q <= count_i;
                        less_q  <= less_i;
                        busy_q  <= 1'b1;
                        state_q <= FIRST;
                    end
                end
                FIRST: begin
                    if (bus.in_valid) begin
                        result_q <= bus.in_data;
                        idx_q    <= '0;
                        k_q      <= {{IDXW{1'b0}}, 1'b1};
                        if (count_q == {{IDXW{1'b0}}, 1'b1}) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (scan_acc) begin
                        // Strict replacement on a negative difference: ties keep the earlier index.
                        if (bus.cmp_msb) begin
                            result_q <= bus.in_data;
                            idx_q    <= k_q[IDXW-1:0];
                        end
                        k_q <= k_d;
                        if (k_d == count_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Min mode asks "in_data - result < 0", max mode asks "result - in_data < 0".
    always_comb begin
        in_ready = 1'b0;
        cmp_req  = 1'b0;
        cmp_a    = '0;
        cmp_b    = '0;
        case (state_q)
            FIRST: in_ready = 1'b1;
            SCAN: begin
                in_ready = bus.cmp_gnt;
                cmp_req  = bus.in_valid;
                if (bus.in_valid) begin
                    if (less_q) begin
                        cmp_a = bus.in_data;
                        cmp_b = result_q;
                    end else begin
                        cmp_a = result_q;
                        cmp_b = bus.in_data;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.cmp_req  = cmp_req;
    assign bus.cmp_a    = cmp_a;
    assign bus.cmp_b    = cmp_b;

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign result_idx_o = idx_q;

endmodule
